stall_collapse_pipe: RTL

- Parametrised in-order pipeline of N-1 register stages carrying a W-bit payload, with a combinational backward stall chain.
- Successor to the fixed-output stall pipeline. Adds output backpressure (out_accept), a partial flush of younger stages, an occupancy count and a saturating input-blocked counter.
- Used as the generic microcode/operand pipe between issue and writeback.
- Bubbles collapse: a stage stalls only if it holds a valid entry.

---
 rtl/stall_collapse_pipe_pkg.sv | 20 ++
 rtl/stall_collapse_ctrl.sv | 60 ++++++
 rtl/stall_collapse_pipe_chk.sv | 29 ++
 rtl/stall_collapse_pipe.sv | 109 ++++++++++
 4 files changed

// File: rtl/stall_collapse_pipe_pkg.sv
// Shared helpers for the stall-collapse pipeline: occupancy width and popcount.
package stall_collapse_pipe_pkg;

  localparam int unsigned MAX_N = 64;
  localparam int unsigned PC_W  = 7;

  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [MAX_N-1:0] vec);
    logic [PC_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_N; i++) begin
      acc = acc + {{(PC_W-1){1'b0}}, vec[i]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/stall_collapse_ctrl.sv
// Kill / stall / advance chain for an N-stage collapsing pipeline.
// Pure combinational so several payload lanes can share one instance.
module stall_collapse_ctrl #(
  parameter int N = 10
) (
  input  logic                 in_vld,
  input  logic [N-1:1]         vld_r,
  input  logic [N-1:0]         stall_req,
  input  logic                 out_accept,
  input  logic                 flush,
  input  logic [$clog2(N)-1:0] flush_stage,
  output logic                 in_accept,
  output logic [N-2:0]         adv,
  output logic [N-1:1]         vld_w
);

  logic [N-2:0] kill;
  logic [N-2:0] v;
  logic [N-1:0] stall;

  // Kill mask and effective valids; the oldest stage can never be flushed.
  always_comb begin
    kill = '0;
    v    = '0;
    for (int i = 0; i <= N-2; i++) begin
      kill[i] = flush && (int'(flush_stage) >= i);
    end
    v[0] = in_vld & ~kill[0];
    for (int i = 1; i <= N-2; i++) begin
      v[i] = vld_r[i] & ~kill[i];
    end
  end

  // Backward stall chain: an empty (or killed) stage breaks it, letting bubbles collapse.
  always_comb begin
    logic s;
    stall        = '0;
    s            = vld_r[N-1] & (stall_req[N-1] | ~out_accept);
    stall[N-1]   = s;
    for (int i = N-2; i >= 1; i--) begin
      s        = v[i] & (stall_req[i] | s);
      stall[i] = s;
    end
    stall[0] = stall_req[0] | s;
  end

  always_comb begin
    adv   = '0;
    vld_w = '0;
    for (int i = 0; i <= N-2; i++) begin
      adv[i] = v[i] & ~stall[i];
    end
    for (int i = 1; i <= N-1; i++) begin
      vld_w[i] = stall[i] | adv[i-1];
    end
  end

  assign in_accept = ~stall[0];

endmodule

// File: rtl/stall_collapse_pipe_chk.sv
// Protocol and sanity checks for stall_collapse_pipe; simulation-only content.
module stall_collapse_pipe_chk #(
  parameter int N = 10,
  parameter int W = 32
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 flush,
  input logic [$clog2(N)-1:0] flush_stage,
  input logic                 out_vld_r,
  input logic                 out_accept,
  input logic [W-1:0]         out_r,
  input logic [$clog2(N):0]   count_r,
  input logic [N-1:1]         vld_r
);

  a_flush_stage_legal: assert property (@(posedge clk) disable iff (rst)
    flush |-> (int'(flush_stage) <= N-2));

  a_out_stable: assert property (@(posedge clk)
    (!rst && out_vld_r && !out_accept) |=> $stable(out_r));

  a_count_max: assert property (@(posedge clk) disable iff (rst)
    int'(count_r) <= N-1);

  a_vld_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(vld_r));

endmodule

// File: rtl/stall_collapse_pipe.sv
// In-order W-bit pipeline of N-1 register stages with collapsing bubbles,
// output backpressure, partial flush, occupancy count and blocked-cycle counter.
module stall_collapse_pipe
  import stall_collapse_pipe_pkg::*;
#(
  parameter int N  = 10,
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         in,
  input  logic                 in_vld,
  output logic                 in_accept,
  output logic [W-1:0]         out_r,
  output logic                 out_vld_r,
  input  logic                 out_accept,
  input  logic [N-1:0]         stall_req,
  input  logic                 flush,
  input  logic [$clog2(N)-1:0] flush_stage,
  output logic [$clog2(N):0]   count_r,
  output logic [CW-1:0]        blk_cnt_r,
  input  logic                 cnt_clr
);

  // N is limited to MAX_N by the popcount helper.
  localparam int CNTW = int'(count_width(N));

  logic [N-2:0]     adv;
  logic [N-1:1]     vld_w;
  logic [N-1:1]     vld_r;
  logic [W-1:0]     data_r [1:N-1];
  logic [MAX_N-1:0] pc_vec;
  logic [PC_W-1:0]  pc;

  stall_collapse_ctrl #(.N(N)) u_ctrl (
    .in_vld      (in_vld),
    .vld_r       (vld_r),
    .stall_req   (stall_req),
    .out_accept  (out_accept),
    .flush       (flush),
    .flush_stage (flush_stage),
    .in_accept   (in_accept),
    .adv         (adv),
    .vld_w       (vld_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= '0;
    end else begin
      vld_r <= vld_w;
    end
  end

  // Payload is not reset; it only moves where the ctrl chain says it advances.
  always_ff @(posedge clk) begin
    if (adv[0]) begin
      data_r[1] <= in;
    end
    for (int i = 2; i < N; i++) begin
      if (adv[i-1]) begin
        data_r[i] <= data_r[i-1];
      end
    end
  end

  always_comb begin
    pc_vec        = '0;
    pc_vec[N-2:0] = vld_w;
  end

  assign pc = popcount(pc_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      count_r <= pc[CNTW-1:0];
    end
  end

  // Saturating count of cycles where the producer was held off.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_r <= '0;
    end else if (cnt_clr) begin
      blk_cnt_r <= '0;
    end else if (in_vld && !in_accept && (blk_cnt_r != {CW{1'b1}})) begin
      blk_cnt_r <= blk_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign out_r     = data_r[N-1];
  assign out_vld_r = vld_r[N-1];

  stall_collapse_pipe_chk #(.N(N), .W(W)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .flush_stage (flush_stage),
    .out_vld_r   (out_vld_r),
    .out_accept  (out_accept),
    .out_r       (out_r),
    .count_r     (count_r),
    .vld_r       (vld_r)
  );

endmodule
